div_ratio_meter: RTL

Measures a slow, clock-like input (typically the output of a clock divider) in units of the system clock `clk`. It reports the period and high time of each cycle, which recovers the divide ratio and duty cycle. It sits on the receive side of timer and divider outputs for self-check and debug readout. The input is asynchronous and is synchronized internally.

---
 rtl/div_ratio_meter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/div_ratio_meter.sv
// div_ratio_meter: measures period and high time of a slow, asynchronous
// clock-like input in units of clk, recovering divide ratio and duty cycle.
// Reports lock when consecutive periods match and flags a sticky overflow
// when no rising edge arrives within the counter range.
module div_ratio_meter #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 locked,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sync;
  logic                 s;
  logic                 s_d;
  logic                 rise;
  logic [CNT_WIDTH-1:0] per_cnt;
  logic [CNT_WIDTH-1:0] hi_cnt;
  // Previous period for lock comparison; zero means "no reference yet",
  // which can never match because a real period is at least 2.
  logic [CNT_WIDTH-1:0] last_period;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // Synchronizer chain and edge-detect flop; free-running in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {SYNC_STAGES{1'b0}};
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d  <= s;
    end
  end

  // Measurement state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      per_cnt     <= CNT_ZERO;
      hi_cnt      <= CNT_ZERO;
      last_period <= CNT_ZERO;
      period      <= CNT_ZERO;
      high_time   <= CNT_ZERO;
      valid       <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        // Results stay readable while disabled; status flags are cleared.
        state    <= IDLE;
        per_cnt  <= CNT_ZERO;
        hi_cnt   <= CNT_ZERO;
        locked   <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state       <= ARM;
            per_cnt     <= CNT_ZERO;
            hi_cnt      <= CNT_ZERO;
            last_period <= CNT_ZERO;
          end
          ARM: begin
            if (rise) begin
              per_cnt <= CNT_ONE;
              hi_cnt  <= CNT_ONE;
              state   <= MEAS;
            end else begin
              per_cnt <= CNT_ZERO;
              hi_cnt  <= CNT_ZERO;
            end
          end
          MEAS: begin
            if (rise) begin
              // A rise on the terminal count still closes a valid period.
              period      <= per_cnt;
              high_time   <= hi_cnt;
              valid       <= 1'b1;
              locked      <= (per_cnt == last_period);
              last_period <= per_cnt;
              per_cnt     <= CNT_ONE;
              hi_cnt      <= CNT_ONE;
            end else if (per_cnt == CNT_MAX) begin
              overflow    <= 1'b1;
              locked      <= 1'b0;
              per_cnt     <= CNT_ZERO;
              hi_cnt      <= CNT_ZERO;
              last_period <= CNT_ZERO;
              state       <= ARM;
            end else begin
              per_cnt <= per_cnt + CNT_ONE;
              if (s) begin
                hi_cnt <= hi_cnt + CNT_ONE;
              end else begin
                hi_cnt <= hi_cnt;
              end
            end
          end
          default: begin
            state   <= IDLE;
            per_cnt <= CNT_ZERO;
            hi_cnt  <= CNT_ZERO;
          end
        endcase
      end
    end
  end

endmodule
